// File: rtl/prio_encoder_rr_pkg.sv
// Shared definitions for the round-robin / fixed-priority encoder.
// Holds the mode encodings and the index-width helper.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n requests, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/result bundle between request sources, the encoder and its consumer.
// The slave modport is the encoder side; the master modport is the environment side.
interface prio_encoder_rr_if
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = idx_width(N)
);
   logic [N-1:0] req;
   logic         mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic [N-1:0] out_onehot;
   logic         out_multi;

   modport master (
      output req,
      output mode,
      output out_ready,
      input  out_valid,
      input  out_idx,
      input  out_onehot,
      input  out_multi
   );

   modport slave (
      input  req,
      input  mode,
      input  out_ready,
      output out_valid,
      output out_idx,
      output out_onehot,
      output out_multi
   );

endinterface

// File: rtl/prio_encoder_rr_pick.sv
// Combinational request picker: highest-index fixed priority, or round-robin from ptr
// with wrap handled by searching a double-width {req, req masked to >= ptr} vector.
module prio_pick
  import prio_enc_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = idx_width(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         mode,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot,
   output logic         any,
   output logic         multi
);

   logic [W-1:0]   fix_idx;
   logic [W-1:0]   rr_idx;
   logic [W:0]     rr_pos;
   logic [N-1:0]   masked;
   logic [2*N-1:0] dbl;

   always_comb begin
      fix_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) fix_idx = W'(i);
      end
   end

   always_comb begin
      masked = '0;
      for (int i = 0; i < N; i++) begin
         masked[i] = req[i] && (i >= int'(ptr));
      end
      dbl = {req, masked};
      // Lowest set bit wins; the upper copy only matters when nothing is at or above ptr.
      rr_pos = '0;
      for (int j = 2 * N - 1; j >= 0; j--) begin
         if (dbl[j]) rr_pos = (W + 1)'(j);
      end
      if (rr_pos >= (W + 1)'(N)) rr_idx = W'(rr_pos - (W + 1)'(N));
      else                       rr_idx = W'(rr_pos);
   end

   always_comb begin
      idx = (mode == MODE_RR) ? rr_idx : fix_idx;
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         onehot[i] = (idx == W'(i));
      end
      any   = |req;
      multi = ($countones(req) > 1);
   end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder with a single-entry valid/ready output stage.
// Holds the result register, capture/accept control and the round-robin pointer.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = idx_width(N)
) (
   input logic              clk,
   input logic              rst,
   prio_encoder_rr_if.slave bus
);

   logic [W-1:0] pick_idx;
   logic [N-1:0] pick_onehot;
   logic         pick_any;
   logic         pick_multi;

   logic         valid_q;
   logic [W-1:0] idx_q;
   logic [N-1:0] onehot_q;
   logic         multi_q;
   logic         mode_q;
   logic [W-1:0] ptr_q;

   logic         capture;
   logic         accept;

   // The search always sees the registered ptr, never the same-cycle update.
   prio_pick #(
      .N (N),
      .W (W)
   ) u_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .mode   (bus.mode),
      .idx    (pick_idx),
      .onehot (pick_onehot),
      .any    (pick_any),
      .multi  (pick_multi)
   );

   assign accept  = valid_q && bus.out_ready;
   assign capture = pick_any && (!valid_q || bus.out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         idx_q    <= '0;
         onehot_q <= '0;
         multi_q  <= 1'b0;
         mode_q   <= MODE_FIXED;
         ptr_q    <= '0;
      end else begin
         if (accept && (mode_q == MODE_RR)) begin
            ptr_q <= (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;
         end
         if (capture) begin
            valid_q  <= 1'b1;
            idx_q    <= pick_idx;
            onehot_q <= pick_onehot;
            multi_q  <= pick_multi;
            mode_q   <= bus.mode;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.out_idx    = idx_q;
   assign bus.out_onehot = onehot_q;
   assign bus.out_multi  = multi_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed self-checking bench for prio_encoder_rr at N=8 and N=5.
module tb_prio_encoder_rr;
   import prio_enc_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   prio_encoder_rr_if #(.N(8)) bus8 ();
   prio_encoder_rr_if #(.N(5)) bus5 ();

   prio_encoder_rr #(.N(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   prio_encoder_rr #(.N(5)) u_dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus8.req = 8'hFF; bus8.mode = MODE_FIXED; bus8.out_ready = 1'b1;
      bus5.req = 5'h00; bus5.mode = MODE_FIXED; bus5.out_ready = 1'b1;
      tick(); tick();
      checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0d want=0", bus8.out_valid); end
      checks++; if (bus8.out_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", bus8.out_idx); end
      checks++; if (bus8.out_onehot !== 8'h00) begin errors++; $display("FAIL reset_onehot got=%h want=00", bus8.out_onehot); end
      checks++; if (bus8.out_multi !== 1'b0) begin errors++; $display("FAIL reset_multi got=%0d want=0", bus8.out_multi); end
      checks++; if (bus5.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid5 got=%0d want=0", bus5.out_valid); end
      rst = 1'b0;
      tick();
      checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL release_valid got=%0d want=1", bus8.out_valid); end
      checks++; if (bus8.out_idx !== 3'd7) begin errors++; $display("FAIL release_idx got=%0d want=7", bus8.out_idx); end
      checks++; if (bus8.out_onehot !== 8'h80) begin errors++; $display("FAIL release_onehot got=%h want=80", bus8.out_onehot); end
      checks++; if (bus8.out_multi !== 1'b1) begin errors++; $display("FAIL release_multi got=%0d want=1", bus8.out_multi); end
   endtask

   task automatic test_fixed_sweep();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) begin
         v = 8'b1 << i;
         bus8.req = v;
         tick();
         checks++; if (bus8.out_idx !== 3'(i)) begin errors++; $display("FAIL sweep_idx[%0d] got=%0d want=%0d", i, bus8.out_idx, i); end
         checks++; if (bus8.out_onehot !== v) begin errors++; $display("FAIL sweep_onehot[%0d] got=%h want=%h", i, bus8.out_onehot, v); end
         checks++; if (bus8.out_multi !== 1'b0) begin errors++; $display("FAIL sweep_multi[%0d] got=%0d want=0", i, bus8.out_multi); end
      end
      bus8.req = 8'h00;
      tick();
      checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%0d want=0", bus8.out_valid); end
      tick();
      checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%0d want=0", bus8.out_valid); end
   endtask

   // Back-to-back accept+capture searches from the pre-update ptr, so each index repeats once.
   task automatic test_rr_fairness();
      int exp_seq [8];
      int e;
      bus8.mode = MODE_RR;
      bus8.req = 8'hFF;
      for (int k = 0; k < 18; k++) begin
         e = (k / 2) % 8;
         tick();
         checks++; if (bus8.out_idx !== 3'(e)) begin errors++; $display("FAIL rr_ff_idx[%0d] got=%0d want=%0d", k, bus8.out_idx, e); end
         checks++; if (bus8.out_multi !== 1'b1) begin errors++; $display("FAIL rr_ff_multi[%0d] got=%0d want=1", k, bus8.out_multi); end
      end
      exp_seq = '{2, 2, 5, 5, 2, 2, 5, 5};
      bus8.req = 8'b0010_0100;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++; if (bus8.out_idx !== 3'(exp_seq[k])) begin errors++; $display("FAIL rr_pair_idx[%0d] got=%0d want=%0d", k, bus8.out_idx, exp_seq[k]); end
      end
   endtask

   task automatic test_backpressure();
      rst = 1'b1; bus8.req = 8'h00;
      tick();
      rst = 1'b0;
      bus8.mode = MODE_RR; bus8.req = 8'h20; bus8.out_ready = 1'b0;
      tick();
      checks++; if (bus8.out_idx !== 3'd5) begin errors++; $display("FAIL bp_capture_idx got=%0d want=5", bus8.out_idx); end
      bus8.req = 8'h01;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%0d want=1", k, bus8.out_valid); end
         checks++; if (bus8.out_idx !== 3'd5) begin errors++; $display("FAIL bp_idx[%0d] got=%0d want=5", k, bus8.out_idx); end
         checks++; if (bus8.out_onehot !== 8'h20) begin errors++; $display("FAIL bp_onehot[%0d] got=%h want=20", k, bus8.out_onehot); end
         checks++; if (u_dut8.ptr_q !== 3'd0) begin errors++; $display("FAIL bp_ptr[%0d] got=%0d want=0", k, u_dut8.ptr_q); end
      end
      bus8.out_ready = 1'b1;
      tick();
      checks++; if (bus8.out_idx !== 3'd0) begin errors++; $display("FAIL bp_release_idx got=%0d want=0", bus8.out_idx); end
      checks++; if (u_dut8.ptr_q !== 3'd6) begin errors++; $display("FAIL bp_release_ptr got=%0d want=6", u_dut8.ptr_q); end
      bus8.out_ready = 1'b0;
      tick();
      checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid got=%0d want=1", bus8.out_valid); end
   endtask

   task automatic test_reset_mid();
      checks++; if (u_dut8.ptr_q !== 3'd6) begin errors++; $display("FAIL mid_pre_ptr got=%0d want=6", u_dut8.ptr_q); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%0d want=0", bus8.out_valid); end
      checks++; if (u_dut8.ptr_q !== 3'd0) begin errors++; $display("FAIL mid_ptr got=%0d want=0", u_dut8.ptr_q); end
      bus8.req = 8'hFF; bus8.mode = MODE_RR; bus8.out_ready = 1'b1;
      tick();
      checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("FAIL mid_next_valid got=%0d want=1", bus8.out_valid); end
      checks++; if (bus8.out_idx !== 3'd0) begin errors++; $display("FAIL mid_next_idx got=%0d want=0", bus8.out_idx); end
   endtask

   task automatic test_non_pow2();
      int exp_seq [8];
      logic [4:0] v;
      exp_seq = '{0, 0, 4, 4, 0, 0, 4, 4};
      bus5.mode = MODE_RR; bus5.req = 5'b10001; bus5.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         v = 5'b1 << exp_seq[k];
         tick();
         checks++; if (bus5.out_idx !== 3'(exp_seq[k])) begin errors++; $display("FAIL np2_idx[%0d] got=%0d want=%0d", k, bus5.out_idx, exp_seq[k]); end
         checks++; if (bus5.out_onehot !== v) begin errors++; $display("FAIL np2_onehot[%0d] got=%b want=%b", k, bus5.out_onehot, v); end
         checks++; if (u_dut5.ptr_q >= 3'd5) begin errors++; $display("FAIL np2_ptr_range[%0d] got=%0d want=<5", k, u_dut5.ptr_q); end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_sweep();
      test_rr_fairness();
      test_backpressure();
      test_reset_mid();
      test_non_pow2();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
